// File: rtl/register_file.sv
// Multi-ported register file: one decoded write port, two combinational read
// ports, optional write-to-read bypass and hardwired zero register.
module register_file #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_W-1:0]    raddr_a,
    input  logic [ADDR_W-1:0]    raddr_b,
    output logic [WIDTH-1:0]     rdata_a,
    output logic [WIDTH-1:0]     rdata_b,
    output logic [2**ADDR_W-1:0] written
);

    localparam int DEPTH = 2**ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BP    = (BYPASS != 0);

    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [WIDTH-1:0]  regs_d [DEPTH];
    logic [DEPTH-1:0]  written_q;
    logic [DEPTH-1:0]  written_d;
    logic [DEPTH-1:0]  wen;
    logic [ADDR_W-1:0] raddr [2];
    logic [WIDTH-1:0]  rdata [2];

    // One-hot write enable; the zero register never gets an enable
    always_comb begin
        wen = '0;
        if (we) begin
            wen[waddr] = 1'b1;
        end
        if (ZR) begin
            wen[0] = 1'b0;
        end
    end

    always_comb begin
        written_d = written_q;
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (wen[i]) begin
                regs_d[i]    = wdata;
                written_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            written_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            written_q <= written_d;
        end
    end

    assign raddr[0] = raddr_a;
    assign raddr[1] = raddr_b;

    // wen already excludes the zero register, so bypass never leaks into r0
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = '0;
            if (rst_n) begin
                if (BP && wen[raddr[p]]) begin
                    rdata[p] = wdata;
                end else if (!(ZR && raddr[p] == '0)) begin
                    rdata[p] = regs_q[raddr[p]];
                end
            end
        end
    end

    assign rdata_a = rdata[0];
    assign rdata_b = rdata[1];
    assign written = written_q;

endmodule

// File: tb/tb_register_file.sv
// Directed vector bench for register_file: default build plus a
// ZERO_REG=0 / BYPASS=0 build driven from the same stimulus.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic [15:0] rdata_a;
    logic [15:0] rdata_b;
    logic [7:0]  written;
    logic [15:0] alt_rdata_a;
    logic [15:0] alt_rdata_b;
    logic [7:0]  alt_written;

    int n_vec = 0;
    int n_bad = 0;

    register_file #(
        .WIDTH(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .written(written)
    );

    register_file #(
        .WIDTH(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)
    ) dut_alt (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(alt_rdata_a), .rdata_b(alt_rdata_b), .written(alt_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  waddr;
        logic [15:0] wdata;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic [7:0]  exp_w;
        logic [15:0] alt_a;
        logic [7:0]  alt_w;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [15:0] ev;
        logic [15:0] ev_alt;

        // Expectations sampled before the vector's write edge
        vt[0]  = '{1, 3, 16'h1234, 3, 3, 16'h1234, 16'h1234, 8'h00, 16'h0000, 8'h00};
        vt[1]  = '{0, 0, 16'h0000, 3, 3, 16'h1234, 16'h1234, 8'h08, 16'h1234, 8'h08};
        vt[2]  = '{0, 0, 16'h0000, 1, 7, 16'h0000, 16'h0000, 8'h08, 16'h0000, 8'h08};
        vt[3]  = '{1, 0, 16'hFFFF, 0, 0, 16'h0000, 16'h0000, 8'h08, 16'h0000, 8'h08};
        vt[4]  = '{0, 0, 16'h0000, 0, 3, 16'h0000, 16'h1234, 8'h08, 16'hFFFF, 8'h09};
        vt[5]  = '{1, 5, 16'h00AA, 4, 2, 16'h0000, 16'h0000, 8'h08, 16'h0000, 8'h09};
        vt[6]  = '{1, 5, 16'h5555, 5, 2, 16'h5555, 16'h0000, 8'h28, 16'h00AA, 8'h29};
        vt[7]  = '{0, 6, 16'hDEAD, 5, 6, 16'h5555, 16'h0000, 8'h28, 16'h5555, 8'h29};
        vt[8]  = '{0, 6, 16'hDEAD, 5, 6, 16'h5555, 16'h0000, 8'h28, 16'h5555, 8'h29};
        vt[9]  = '{0, 6, 16'hDEAD, 5, 6, 16'h5555, 16'h0000, 8'h28, 16'h5555, 8'h29};
        vt[10] = '{1, 6, 16'h1111, 6, 6, 16'h1111, 16'h1111, 8'h28, 16'h0000, 8'h29};
        vt[11] = '{1, 6, 16'h2222, 6, 1, 16'h2222, 16'h0000, 8'h68, 16'h1111, 8'h69};
        vt[12] = '{0, 6, 16'h0000, 6, 5, 16'h2222, 16'h5555, 8'h68, 16'h2222, 8'h69};

        rst_n   = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        raddr_a = 3'd4;
        raddr_b = 3'd7;
        #1;
        chk("reset_rdata_a", rdata_a, 16'h0000);
        chk("reset_rdata_b", rdata_b, 16'h0000);
        chk("reset_written", {8'h00, written}, 16'h0000);
        chk("reset_alt_written", {8'h00, alt_written}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            we      = vt[i].we;
            waddr   = vt[i].waddr;
            wdata   = vt[i].wdata;
            raddr_a = vt[i].ra;
            raddr_b = vt[i].rb;
            #1;
            chk($sformatf("v%0d_rdata_a", i), rdata_a, vt[i].exp_a);
            chk($sformatf("v%0d_rdata_b", i), rdata_b, vt[i].exp_b);
            chk($sformatf("v%0d_written", i), {8'h00, written},
                {8'h00, vt[i].exp_w});
            chk($sformatf("v%0d_alt_rdata_a", i), alt_rdata_a, vt[i].alt_a);
            chk($sformatf("v%0d_alt_written", i), {8'h00, alt_written},
                {8'h00, vt[i].alt_w});
        end

        // Fill r1..r7 with 0x0101*i and read every register back
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            we    = 1'b1;
            waddr = 3'(i);
            wdata = 16'(16'h0101 * i);
        end
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i);
            raddr_b = 3'(7 - i);
            #1;
            ev     = (i == 0) ? 16'h0000 : 16'(16'h0101 * i);
            ev_alt = (i == 0) ? 16'hFFFF : 16'(16'h0101 * i);
            chk($sformatf("fill_r%0d_a", i), rdata_a, ev);
            chk($sformatf("fill_r%0d_b", i), rdata_b,
                (i == 7) ? 16'h0000 : 16'(16'h0101 * (7 - i)));
            chk($sformatf("fill_r%0d_alt_a", i), alt_rdata_a, ev_alt);
        end
        chk("fill_written", {8'h00, written}, 16'h00FE);
        chk("fill_alt_written", {8'h00, alt_written}, 16'h00FF);

        // Write 0xBEEF to r4, then reset asynchronously mid-cycle
        @(negedge clk);
        we      = 1'b1;
        waddr   = 3'd4;
        wdata   = 16'hBEEF;
        raddr_a = 3'd4;
        raddr_b = 3'd4;
        @(posedge clk);
        #2;
        we = 1'b0;
        #1;
        chk("beef_stored", rdata_a, 16'hBEEF);
        chk("beef_alt_stored", alt_rdata_b, 16'hBEEF);
        rst_n = 1'b0;
        #1;
        chk("async_rst_a", rdata_a, 16'h0000);
        chk("async_rst_b", rdata_b, 16'h0000);
        chk("async_rst_written", {8'h00, written}, 16'h0000);
        chk("async_rst_alt_a", alt_rdata_a, 16'h0000);
        chk("async_rst_alt_written", {8'h00, alt_written}, 16'h0000);

        // A write attempted while reset is held must lose
        we    = 1'b1;
        wdata = 16'hBEEF;
        #1;
        chk("rst_no_bypass", rdata_a, 16'h0000);
        @(posedge clk);
        #1;
        chk("rst_wins_a", rdata_a, 16'h0000);
        chk("rst_wins_written", {8'h00, written}, 16'h0000);
        chk("rst_wins_alt_a", alt_rdata_a, 16'h0000);

        // First edge after release performs a normal write
        @(negedge clk);
        rst_n   = 1'b1;
        waddr   = 3'd2;
        wdata   = 16'h7777;
        raddr_b = 3'd2;
        #1;
        chk("release_r4", rdata_a, 16'h0000);
        chk("release_bypass", rdata_b, 16'h7777);
        chk("release_alt_prewrite", alt_rdata_b, 16'h0000);
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        chk("release_r2", rdata_b, 16'h7777);
        chk("release_r4_hold", rdata_a, 16'h0000);
        chk("release_written", {8'h00, written}, 16'h0004);
        chk("release_alt_r2", alt_rdata_b, 16'h7777);
        chk("release_alt_written", {8'h00, alt_written}, 16'h0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
